// File: rtl/dl_updown_counter.sv
// dl_updown_counter: up/down counter with runtime limit, wrap/saturate mode, enable prescaler and registered ovf pulse
module dl_updown_counter #(
  parameter int NUM_BITS  = 8,
  parameter int RESET_VAL = 0,
  parameter bit SATURATE  = 1'b0,
  parameter int PRESCALE  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_val,
  input  logic [NUM_BITS-1:0] max_val,
  output logic [NUM_BITS-1:0] q,
  output logic                ovf,
  output logic                at_max,
  output logic                at_zero
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [NUM_BITS-1:0] RV = NUM_BITS'(RESET_VAL);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] ps, ps_nxt;
  logic [NUM_BITS-1:0] q_step, q_nxt;
  logic fire, above, bnd, ovf_nxt;
  assign at_max = q == max_val, at_zero = q == '0;
  // A count left above a lowered max_val snaps to max_val without signalling a boundary
  always_comb begin
    fire = en && ps == PS_LAST;
    above = q > max_val;
    bnd = !above && (up ? at_max : at_zero);
    q_step = above ? max_val : bnd ? (SATURATE ? q : (up ? '0 : max_val)) : (up ? q + NUM_BITS'(1) : q - NUM_BITS'(1));
    q_nxt = clr ? RV : load ? (load_val > max_val ? max_val : load_val) : fire ? q_step : q;
    ps_nxt = (clr || load || fire) ? '0 : en ? ps + PW'(1) : ps;
    ovf_nxt = !clr && !load && fire && bnd;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RV;
      ps <= '0;
      ovf <= 1'b0;
    end else begin
      q <= q_nxt;
      ps <= ps_nxt;
      ovf <= ovf_nxt;
    end
  end
endmodule

// File: tb/tb_dl_updown_counter.sv
// tb_dl_updown_counter: three counter configurations (wrap, saturate, prescale-by-3) on shared stimulus, scoreboard-checked
module tb_dl_updown_counter;
  logic clk = 0, rst_n = 0, en = 0, up = 1, clr = 0, load = 0;
  logic [3:0] load_val = 0, max_val = 9;
  logic [3:0] q[3];
  logic ovf[3], at_max[3], at_zero[3];
  int n_chk = 0, n_fail = 0, ncyc = 0;
  typedef struct { string tag; int id; logic [3:0] q; logic ovf; } exp_t;
  exp_t sb[$];
  logic [3:0] mq[3];
  int mps[3];

  always #5 clk = ~clk;

  dl_updown_counter #(.NUM_BITS(4), .RESET_VAL(0), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .max_val(max_val), .q(q[0]), .ovf(ovf[0]), .at_max(at_max[0]), .at_zero(at_zero[0]));
  dl_updown_counter #(.NUM_BITS(4), .RESET_VAL(0), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .max_val(max_val), .q(q[1]), .ovf(ovf[1]), .at_max(at_max[1]), .at_zero(at_zero[1]));
  dl_updown_counter #(.NUM_BITS(4), .RESET_VAL(2), .SATURATE(1'b0), .PRESCALE(3)) u_ps (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .max_val(max_val), .q(q[2]), .ovf(ovf[2]), .at_max(at_max[2]), .at_zero(at_zero[2]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock: apply priorities, prescaler and boundary rules
  task automatic model();
    for (int i = 0; i < 3; i++) begin
      logic o;
      int psc;
      logic [3:0] rv;
      logic sat;
      o = 0;
      psc = (i == 2) ? 3 : 1;
      rv = (i == 2) ? 4'd2 : 4'd0;
      sat = (i == 1);
      if (!rst_n || clr) begin
        mq[i] = rv;
        mps[i] = 0;
      end else if (load) begin
        mq[i] = (load_val > max_val) ? max_val : load_val;
        mps[i] = 0;
      end else if (en) begin
        if (mps[i] < psc - 1) mps[i]++;
        else begin
          mps[i] = 0;
          if (mq[i] > max_val) mq[i] = max_val;
          else if (up) begin
            if (mq[i] == max_val) begin o = 1; if (!sat) mq[i] = 0; end
            else mq[i] = mq[i] + 4'd1;
          end else begin
            if (mq[i] == 0) begin o = 1; if (!sat) mq[i] = max_val; end
            else mq[i] = mq[i] - 4'd1;
          end
        end
      end
      sb.push_back('{$sformatf("cyc%0d_u%0d", ncyc, i), i, mq[i], o});
    end
  endtask

  task automatic cyc(input int n = 1);
    exp_t e;
    repeat (n) begin
      model();
      @(posedge clk);
      #1;
      ncyc++;
      for (int i = 0; i < 3; i++) begin
        e = sb.pop_front();
        chk({e.tag, "_q"}, q[e.id], e.q);
        chk({e.tag, "_ovf"}, {3'b0, ovf[e.id]}, {3'b0, e.ovf});
        chk({e.tag, "_at_max"}, {3'b0, at_max[e.id]}, {3'b0, e.q == max_val});
        chk({e.tag, "_at_zero"}, {3'b0, at_zero[e.id]}, {3'b0, e.q == 4'd0});
      end
    end
  endtask

  task automatic drv(input logic r, input logic e, input logic u, input logic c, input logic l,
                     input logic [3:0] lv, input logic [3:0] mv);
    rst_n = r; en = e; up = u; clr = c; load = l; load_val = lv; max_val = mv;
  endtask

  initial begin
    drv(0, 1, 1, 0, 1, 5, 9);
    cyc(2);
    chk("reset_q_wrap", q[0], 4'd0);
    chk("reset_q_ps", q[2], 4'd2);
    chk("reset_ovf", {3'b0, ovf[0]}, 4'd0);
    drv(1, 0, 1, 0, 1, 0, 9);
    cyc(1);
    drv(1, 1, 1, 0, 0, 0, 9);
    cyc(9);
    chk("wrap_q9", q[0], 4'd9);
    chk("wrap_at_max", {3'b0, at_max[0]}, 4'd1);
    chk("wrap_ovf_before", {3'b0, ovf[0]}, 4'd0);
    cyc(1);
    chk("wrap_q0", q[0], 4'd0);
    chk("wrap_ovf", {3'b0, ovf[0]}, 4'd1);
    cyc(1);
    chk("wrap_ovf_drop", {3'b0, ovf[0]}, 4'd0);
    drv(1, 0, 0, 0, 1, 2, 9);
    cyc(1);
    drv(1, 1, 0, 0, 0, 0, 9);
    cyc(2);
    chk("sat_q0", q[1], 4'd0);
    chk("sat_ovf_first", {3'b0, ovf[1]}, 4'd0);
    cyc(3);
    chk("sat_hold", q[1], 4'd0);
    chk("sat_ovf_held", {3'b0, ovf[1]}, 4'd1);
    drv(1, 0, 1, 0, 1, 0, 9);
    cyc(1);
    drv(1, 1, 1, 0, 0, 0, 9);
    cyc(9);
    chk("ps_q3", q[2], 4'd3);
    cyc(1);
    en = 0;
    cyc(2);
    chk("ps_hold", q[2], 4'd3);
    en = 1;
    cyc(1);
    chk("ps_resume_wait", q[2], 4'd3);
    cyc(1);
    chk("ps_resume_step", q[2], 4'd4);
    drv(1, 1, 1, 1, 1, 7, 9);
    cyc(1);
    chk("prio_clr_wrap", q[0], 4'd0);
    chk("prio_clr_ps", q[2], 4'd2);
    drv(1, 0, 1, 0, 1, 12, 9);
    cyc(1);
    chk("load_clamp", q[0], 4'd9);
    drv(1, 1, 1, 0, 0, 0, 5);
    cyc(1);
    chk("lower_max_q", q[0], 4'd5);
    chk("lower_max_ovf", {3'b0, ovf[0]}, 4'd0);
    drv(1, 0, 1, 0, 1, 6, 9);
    cyc(1);
    drv(1, 1, 1, 0, 0, 0, 9);
    cyc(5);
    chk("midcount_q7", q[2], 4'd7);
    rst_n = 0;
    cyc(1);
    chk("midreset_q", q[2], 4'd2);
    rst_n = 1;
    cyc(2);
    chk("midreset_ps_wait", q[2], 4'd2);
    cyc(1);
    chk("midreset_first_step", q[2], 4'd3);
    drv(1, 0, 1, 0, 1, 0, 0);
    cyc(1);
    drv(1, 1, 1, 0, 0, 0, 0);
    cyc(3);
    chk("max0_q", q[0], 4'd0);
    chk("max0_ovf_up", {3'b0, ovf[0]}, 4'd1);
    up = 0;
    cyc(1);
    chk("max0_ovf_down", {3'b0, ovf[1]}, 4'd1);
    for (int k = 0; k < 400; k++) begin
      drv($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, 4'($urandom),
          ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(6, 15)));
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
